stack_queue_buffer: RTL and testbench
=====================================

// Module: stack_queue_buffer
// PURPOSE
//  Parametrised LIFO/FIFO buffer; successor to the fixed 16x8 stack. Mode is selectable at run time.
//  Supports simultaneous push and pop, occupancy count, almost-full/almost-empty and error flags.
//  Sits between a producer/consumer pair wherever the design needs stack or queue storage.
// PARAMETERS
//  DATA_WIDTH    8          width of each entry
//  DEPTH         16         number of entries; power of two, >= 4
//  AFULL_LEVEL   DEPTH-2    ALMOST_FULL asserted when COUNT >= AFULL_LEVEL
//  AEMPTY_LEVEL  2          ALMOST_EMPTY asserted when COUNT <= AEMPTY_LEVEL
// PORTS
//  Clk          in   1                    clock, rising edge
//  Rst          in   1                    synchronous reset, active-high
//  MODE_SEL     in   1                    requested mode: 0 = LIFO, 1 = FIFO
//  PUSH         in   1                    write request
//  POP          in   1                    read request
//  dataIn       in   DATA_WIDTH           write data
//  dataOut      out  DATA_WIDTH           popped data (registered)
//  OUT_VALID    out  1                    dataOut updated this cycle (1-cycle pulse)
//  MODE_ACT     out  1                    mode currently in force
//  COUNT        out  $clog2(DEPTH)+1      occupancy, 0..DEPTH
//  EMPTY        out  1                    COUNT == 0
//  FULL         out  1                    COUNT == DEPTH
//  ALMOST_FULL  out  1                    COUNT >= AFULL_LEVEL
//  ALMOST_EMPTY out  1                    COUNT <= AEMPTY_LEVEL
//  OVERFLOW     out  1                    1-cycle pulse: push rejected
//  UNDERFLOW    out  1                    1-cycle pulse: pop rejected
// BEHAVIOUR
//  - Reset: COUNT=0, pointers=0, dataOut=0, OUT_VALID=0, OVERFLOW=0, UNDERFLOW=0, MODE_ACT=0 (LIFO).
//    Memory contents are not cleared.
//  - Flags EMPTY/FULL/ALMOST_* are combinational from the COUNT register.
//  - Mode: MODE_ACT <= MODE_SEL on any cycle with COUNT==0 && !PUSH; MODE_SEL ignored otherwise.
//    A mode load also clears rd_ptr and wr_ptr.
//  - Pop latency 1: pop accepted at edge N -> dataOut valid and OUT_VALID=1 after edge N.
//    dataOut holds its value until the next accepted pop.
//  - LIFO (stack pointer = COUNT):
//      push only -> mem[COUNT]=dataIn, COUNT+1
//      pop only  -> dataOut=mem[COUNT-1], COUNT-1
//      push+pop, COUNT>0 (including full) -> dataOut=old mem[COUNT-1]; mem[COUNT-1]=dataIn; COUNT unchanged
//  - FIFO:
//      push -> mem[wr_ptr]=dataIn, wr_ptr+1 mod DEPTH
//      pop  -> dataOut=mem[rd_ptr], rd_ptr+1 mod DEPTH
//      push+pop, COUNT>0 (including full) -> both performed; COUNT unchanged; read returns old data
//  - Empty + PUSH + POP (either mode): push accepted, pop rejected; UNDERFLOW=1, COUNT=1. No bypass.
//  - Full + PUSH, no POP: write dropped, OVERFLOW=1, state unchanged.
//  - Empty + POP, no PUSH: UNDERFLOW=1, dataOut unchanged, OUT_VALID=0.
//  - Rst asserted mid-operation: reset values apply at that edge and override all requests.
// CONFIGURATION
//  STACK_QUEUE_PEEK_EN defined: adds ports peekData [DATA_WIDTH] out and peekValid [1] out.
//    peekData is combinational: next entry to pop (LIFO mem[COUNT-1], FIFO mem[rd_ptr]).
//    peekValid = !EMPTY. Peeking does not change any state.
//  Not defined: neither port exists; no read mux beyond the pop path.
// STRUCTURE
//  Package stack_queue_pkg:
//    mode_e typedef (MODE_LIFO=1'b0, MODE_FIFO=1'b1)
//    ptr_w(depth)/cnt_w(depth) width functions
//  Sub-module sqb_regfile: DEPTH x DATA_WIDTH array, 1 sync write port, 1 async read port
//    (2 read ports when STACK_QUEUE_PEEK_EN is defined).
//  Top level holds COUNT, pointers, mode register, the accept/reject decode and the output registers.
// TESTING
//  1. Reset, LIFO: push 0x11,0x22,0x33, pop x3 -> dataOut 0x33,0x22,0x11 (each 1 cycle after its pop), EMPTY=1.
//  2. MODE_SEL=1 while empty, push 0xA0..0xA3, pop x4 -> 0xA0..0xA3 in order; MODE_ACT=1.
//  3. FIFO, fill to 16 -> FULL=1; push 0xFF -> OVERFLOW pulse, COUNT=16.
//     Push+pop together -> COUNT=16, dataOut=first entry; wr/rd pointers wrap to 0.
//  4. LIFO, COUNT=3 (top 0x33), push 0x44 + pop together -> dataOut=0x33, COUNT=3; next pop -> 0x44.
//  5. Empty, push 0x5A + pop together -> UNDERFLOW=1, OUT_VALID=0, COUNT=1.
//     Toggle MODE_SEL while COUNT=1 -> MODE_ACT unchanged.
//  6. DEPTH=16, AFULL=14, AEMPTY=2: sweep COUNT 0..16 -> ALMOST_EMPTY for 0..2, ALMOST_FULL for 14..16.
//     Rst mid-fill -> COUNT=0, dataOut=0 next cycle.

Source files
------------

// File: rtl/stack_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : stack_queue_pkg
// Brief  : Shared mode encoding and width helpers for stack_queue_buffer.
// Rev    : 1.0
// ============================================================================
package stack_queue_pkg;

  typedef enum logic {
    MODE_LIFO = 1'b0,
    MODE_FIFO = 1'b1
  } mode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqb_regfile.sv
`default_nettype none
// ============================================================================
// Module : sqb_regfile
// Brief  : DEPTH x DATA_WIDTH storage, one sync write port, async read port(s).
//          STACK_QUEUE_PEEK_EN adds a second async read port.
// Rev    : 1.0
// ============================================================================
import stack_queue_pkg::*;

module sqb_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]     o_rdata
`ifdef STACK_QUEUE_PEEK_EN
  ,
  input  logic [ptr_w(DEPTH)-1:0]   i_paddr,
  output logic [DATA_WIDTH-1:0]     o_pdata
`endif
);

  // Contents are deliberately never reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

`ifdef STACK_QUEUE_PEEK_EN
  assign o_pdata = r_mem[i_paddr];
`endif

endmodule
`default_nettype wire

// File: rtl/stack_queue_buffer.sv
`default_nettype none
// ============================================================================
// Module : stack_queue_buffer
// Brief  : Run-time selectable LIFO/FIFO buffer with count and status flags.
//          STACK_QUEUE_PEEK_EN adds peekData/peekValid outputs.
// Rev    : 1.0
// ============================================================================
import stack_queue_pkg::*;

module stack_queue_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      MODE_SEL,
  input  logic                      PUSH,
  input  logic                      POP,
  input  logic [DATA_WIDTH-1:0]     dataIn,
  output logic [DATA_WIDTH-1:0]     dataOut,
  output logic                      OUT_VALID,
  output logic                      MODE_ACT,
  output logic [cnt_w(DEPTH)-1:0]   COUNT,
  output logic                      EMPTY,
  output logic                      FULL,
  output logic                      ALMOST_FULL,
  output logic                      ALMOST_EMPTY,
  output logic                      OVERFLOW,
  output logic                      UNDERFLOW
`ifdef STACK_QUEUE_PEEK_EN
  ,
  output logic [DATA_WIDTH-1:0]     peekData,
  output logic                      peekValid
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] c_depth  = CW'(DEPTH);
  localparam logic [CW-1:0] c_afull  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] c_aempty = CW'(AEMPTY_LEVEL);

  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  mode_e                 r_mode;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_valid;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic                  w_mode_ld;
  logic [PW-1:0]         w_top;
  logic [PW-1:0]         w_waddr;
  logic [PW-1:0]         w_raddr;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_depth);
  // A full buffer still takes a push when a pop frees the slot in the same cycle.
  assign w_push_acc = PUSH && (!w_full || POP);
  assign w_pop_acc  = POP && !w_empty;
  assign w_mode_ld  = w_empty && !PUSH;

  // Low bits of COUNT wrap correctly when COUNT == DEPTH.
  assign w_top   = r_count[PW-1:0] - PW'(1);
  assign w_raddr = (r_mode == MODE_FIFO) ? r_rd_ptr : w_top;
  assign w_waddr = (r_mode == MODE_FIFO) ? r_wr_ptr :
                   (w_pop_acc ? w_top : r_count[PW-1:0]);

  sqb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk     (Clk),
    .i_we    (w_push_acc),
    .i_waddr (w_waddr),
    .i_wdata (dataIn),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
`ifdef STACK_QUEUE_PEEK_EN
    ,
    .i_paddr (w_raddr),
    .o_pdata (peekData)
`endif
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mode   <= MODE_LIFO;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_valid <= w_pop_acc;
      r_ovf   <= PUSH && w_full && !POP;
      r_udf   <= POP && w_empty;
      if (w_pop_acc) begin
        r_dout <= w_rdata;
      end
      if (w_push_acc && !w_pop_acc) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_acc && !w_push_acc) begin
        r_count <= r_count - CW'(1);
      end
      if (w_mode_ld) begin
        r_mode   <= MODE_SEL ? MODE_FIFO : MODE_LIFO;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else if (r_mode == MODE_FIFO) begin
        if (w_push_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  assign dataOut      = r_dout;
  assign OUT_VALID    = r_valid;
  assign MODE_ACT     = r_mode;
  assign COUNT        = r_count;
  assign EMPTY        = w_empty;
  assign FULL         = w_full;
  assign ALMOST_FULL  = (r_count >= c_afull);
  assign ALMOST_EMPTY = (r_count <= c_aempty);
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_udf;

`ifdef STACK_QUEUE_PEEK_EN
  assign peekValid = !w_empty;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stack_queue_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_stack_queue_buffer
// Brief  : Directed table-driven bench for stack_queue_buffer (16 x 8).
// Rev    : 1.0
// ============================================================================
module tb_stack_queue_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_sel;
  logic       push;
  logic       pop;
  logic [7:0] din;
  logic [7:0] dout;
  logic       ovalid;
  logic       mode_act;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       afull;
  logic       aempty;
  logic       ovf;
  logic       udf;
`ifdef STACK_QUEUE_PEEK_EN
  logic [7:0] peek_data;
  logic       peek_valid;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_queue_buffer #(
    .DATA_WIDTH   (8),
    .DEPTH        (16),
    .AFULL_LEVEL  (14),
    .AEMPTY_LEVEL (2)
  ) dut (
    .Clk          (clk),
    .Rst          (rst),
    .MODE_SEL     (mode_sel),
    .PUSH         (push),
    .POP          (pop),
    .dataIn       (din),
    .dataOut      (dout),
    .OUT_VALID    (ovalid),
    .MODE_ACT     (mode_act),
    .COUNT        (count),
    .EMPTY        (empty),
    .FULL         (full),
    .ALMOST_FULL  (afull),
    .ALMOST_EMPTY (aempty),
    .OVERFLOW     (ovf),
    .UNDERFLOW    (udf)
`ifdef STACK_QUEUE_PEEK_EN
    ,
    .peekData     (peek_data),
    .peekValid    (peek_valid)
`endif
  );

  typedef struct {
    logic       ms;
    logic       pu;
    logic       po;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic       e_val;
    logic [4:0] e_cnt;
    logic       e_mode;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic ms, logic pu, logic po, logic [7:0] d,
                              logic [7:0] e_dout, logic e_val, logic [4:0] e_cnt,
                              logic e_mode, logic e_ovf, logic e_udf);
    vq.push_back('{ms, pu, po, d, e_dout, e_val, e_cnt, e_mode, e_ovf, e_udf});
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 ns after the following rising edge.
  task automatic cyc(logic ms, logic pu, logic po, logic [7:0] d);
    @(negedge clk);
    mode_sel = ms;
    push     = pu;
    pop      = po;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(string nm, int c);
    chk({nm, "_count"},  32'(count),  32'(c));
    chk({nm, "_empty"},  32'(empty),  32'(c == 0));
    chk({nm, "_full"},   32'(full),   32'(c == 16));
    chk({nm, "_afull"},  32'(afull),  32'(c >= 14));
    chk({nm, "_aempty"}, 32'(aempty), 32'(c <= 2));
  endtask

  initial begin
    rst = 1'b1; mode_sel = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(ovalid), 32'h0);
    chk("rst_mode", 32'(mode_act), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_udf", 32'(udf), 32'h0);
    chk_flags("rst", 0);
    rst = 1'b0;

    // LIFO ordering
    add(0, 1, 0, 8'h11, 8'h00, 0, 1, 0, 0, 0);
    add(0, 1, 0, 8'h22, 8'h00, 0, 2, 0, 0, 0);
    add(0, 1, 0, 8'h33, 8'h00, 0, 3, 0, 0, 0);
    add(0, 0, 1, 8'h00, 8'h33, 1, 2, 0, 0, 0);
    add(0, 0, 1, 8'h00, 8'h22, 1, 1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 8'h11, 1, 0, 0, 0, 0);
    // Switch to FIFO while empty, FIFO ordering
    add(1, 0, 0, 8'h00, 8'h11, 0, 0, 1, 0, 0);
    add(1, 1, 0, 8'hA0, 8'h11, 0, 1, 1, 0, 0);
    add(1, 1, 0, 8'hA1, 8'h11, 0, 2, 1, 0, 0);
    add(1, 1, 0, 8'hA2, 8'h11, 0, 3, 1, 0, 0);
    add(1, 1, 0, 8'hA3, 8'h11, 0, 4, 1, 0, 0);
    add(1, 0, 1, 8'h00, 8'hA0, 1, 3, 1, 0, 0);
    add(1, 0, 1, 8'h00, 8'hA1, 1, 2, 1, 0, 0);
    add(1, 0, 1, 8'h00, 8'hA2, 1, 1, 1, 0, 0);
    add(1, 0, 1, 8'h00, 8'hA3, 1, 0, 1, 0, 0);
    // Underflow on empty pop; empty push+pop takes the push only
    add(1, 0, 1, 8'h00, 8'hA3, 0, 0, 1, 0, 1);
    add(1, 1, 1, 8'h5A, 8'hA3, 0, 1, 1, 0, 1);
    // MODE_SEL ignored while not empty
    add(0, 0, 0, 8'h00, 8'hA3, 0, 1, 1, 0, 0);
    add(0, 0, 1, 8'h00, 8'h5A, 1, 0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 8'h5A, 0, 0, 0, 0, 0);
    // LIFO simultaneous push+pop replaces the top
    add(0, 1, 0, 8'h11, 8'h5A, 0, 1, 0, 0, 0);
    add(0, 1, 0, 8'h22, 8'h5A, 0, 2, 0, 0, 0);
    add(0, 1, 0, 8'h33, 8'h5A, 0, 3, 0, 0, 0);
    add(0, 1, 1, 8'h44, 8'h33, 1, 3, 0, 0, 0);
    add(0, 0, 1, 8'h00, 8'h44, 1, 2, 0, 0, 0);
    add(0, 0, 1, 8'h00, 8'h22, 1, 1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 8'h11, 1, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].ms, vq[i].pu, vq[i].po, vq[i].din);
      chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vq[i].e_dout));
      chk($sformatf("v%0d_valid", i), 32'(ovalid), 32'(vq[i].e_val));
      chk($sformatf("v%0d_mode", i), 32'(mode_act), 32'(vq[i].e_mode));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vq[i].e_ovf));
      chk($sformatf("v%0d_udf", i), 32'(udf), 32'(vq[i].e_udf));
      chk_flags($sformatf("v%0d", i), int'(vq[i].e_cnt));
    end

    // FIFO fill with flag sweep, overflow, full push+pop and pointer wrap
    cyc(1, 0, 0, 8'h00);
    chk("fifo_mode", 32'(mode_act), 32'h1);
    chk_flags("sweep0", 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0, 8'h80 + 8'(i));
      chk_flags($sformatf("sweep%0d", i + 1), i + 1);
    end
    cyc(1, 1, 0, 8'hFF);
    chk("ovf_pulse", 32'(ovf), 32'h1);
    chk("ovf_valid", 32'(ovalid), 32'h0);
    chk_flags("ovf", 16);
    cyc(1, 0, 0, 8'h00);
    chk("ovf_clear", 32'(ovf), 32'h0);
    cyc(1, 1, 1, 8'hEE);
    chk("fullpp_dout", 32'(dout), 32'h80);
    chk("fullpp_valid", 32'(ovalid), 32'h1);
    chk("fullpp_ovf", 32'(ovf), 32'h0);
    chk_flags("fullpp", 16);
    for (int i = 1; i < 16; i++) begin
      cyc(1, 0, 1, 8'h00);
      chk($sformatf("drain%0d_dout", i), 32'(dout), 32'(8'h80 + 8'(i)));
      chk($sformatf("drain%0d_count", i), 32'(count), 32'(16 - i));
    end
    cyc(1, 0, 1, 8'h00);
    chk("wrap_dout", 32'(dout), 32'hEE);
    chk_flags("wrap", 0);

    // Reset in the middle of activity overrides a pending push
    cyc(1, 1, 0, 8'hC1);
    cyc(1, 1, 0, 8'hC2);
    cyc(1, 0, 1, 8'h00);
    chk("pre_rst_dout", 32'(dout), 32'hC1);
    rst = 1'b1;
    cyc(1, 1, 0, 8'hC3);
    rst = 1'b0;
    chk("midrst_dout", 32'(dout), 32'h0);
    chk("midrst_valid", 32'(ovalid), 32'h0);
    chk("midrst_mode", 32'(mode_act), 32'h0);
    chk_flags("midrst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
